// File: rtl/reaction_stats.sv
// rtl/reaction_stats.sv - reaction-time statistics: count, min, max and serial-divided average (optional foul counter: REACTION_STATS_FOUL_CNT_EN)
module reaction_stats #(
    parameter int MAX_TESTS = 15,
    parameter int TIME_W    = 10
) (
    input  logic              clk_50M,
    input  logic              clear,
    input  logic              result_valid,
    input  logic [TIME_W-1:0] result_time,
    input  logic              result_foul,
    output logic [5:0]        test_count,
    output logic [TIME_W-1:0] min_time,
    output logic [TIME_W-1:0] max_time,
    output logic [TIME_W-1:0] avg_time,
    output logic              avg_valid,
    output logic              full,
    output logic [5:0]        foul_count
);

    // Sum is sized so MAX_TESTS results of the largest value can never overflow it.
    localparam int SUM_W = TIME_W + $clog2(MAX_TESTS + 1);
    localparam int STEP_W = $clog2(SUM_W + 1);
    localparam logic [TIME_W-1:0] TIME_CAP = TIME_W'(999);
    localparam logic [5:0] MAX_CNT = 6'(MAX_TESTS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DIV  = 1'b1;

    logic [0:0]        state;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [5:0]        count_next;
    logic [TIME_W-1:0] t_clamped;
    logic              accept;

    // Divider working registers: the quotient shifts in where the dividend shifts out.
    logic [SUM_W-1:0]  div_quo;
    logic [5:0]        div_den;
    logic [5:0]        div_rem;
    logic [STEP_W-1:0] div_step;
    logic [6:0]        rem_shift;
    logic [5:0]        rem_sub;

    assign t_clamped  = (result_time > TIME_CAP) ? TIME_CAP : result_time;
    assign full       = (test_count == MAX_CNT);
    assign accept     = result_valid & ~result_foul & ~full;
    assign sum_next   = sum + SUM_W'(t_clamped);
    assign count_next = test_count + 6'd1;

    // Remainder stays below the divisor (<= 63), so the 6-bit difference is exact when taken.
    assign rem_shift = {div_rem, div_quo[SUM_W-1]};
    assign rem_sub   = rem_shift[5:0] - div_den;

    // Running statistics, updated only on accepted non-foul results.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            sum        <= '0;
            test_count <= '0;
            min_time   <= '1;
            max_time   <= '0;
        end else if (accept) begin
            sum        <= sum_next;
            test_count <= count_next;
            if (t_clamped < min_time) min_time <= t_clamped;
            if (t_clamped > max_time) max_time <= t_clamped;
        end
    end

    // Restoring divider; a new accept restarts it with fresh operands from either state.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            avg_time  <= '0;
            avg_valid <= 1'b1;
            div_quo   <= '0;
            div_den   <= '0;
            div_rem   <= '0;
            div_step  <= '0;
        end else if (accept) begin
            state     <= DIV;
            avg_valid <= 1'b0;
            div_quo   <= sum_next;
            div_den   <= count_next;
            div_rem   <= '0;
            div_step  <= '0;
        end else if (state == DIV) begin
            if (div_step == LAST_STEP) begin
                avg_time  <= TIME_W'(div_quo);
                avg_valid <= 1'b1;
                state     <= IDLE;
            end else begin
                if (rem_shift >= {1'b0, div_den}) begin
                    div_rem <= rem_sub;
                    div_quo <= {div_quo[SUM_W-2:0], 1'b1};
                end else begin
                    div_rem <= rem_shift[5:0];
                    div_quo <= {div_quo[SUM_W-2:0], 1'b0};
                end
                div_step <= div_step + STEP_W'(1);
            end
        end
    end

`ifdef REACTION_STATS_FOUL_CNT_EN
    // Foul counter saturates at 63 and keeps counting even when the result table is full.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            foul_count <= '0;
        end else if (result_valid && result_foul && foul_count != 6'd63) begin
            foul_count <= foul_count + 6'd1;
        end
    end
`else
    assign foul_count = '0;
`endif

endmodule

// File: tb/tb_reaction_stats.sv
// tb/tb_reaction_stats.sv - scoreboard bench for reaction_stats
module tb_reaction_stats;

    logic       clk_50M = 1'b0;
    logic       clear;
    logic       result_valid;
    logic [9:0] result_time;
    logic       result_foul;
    logic [5:0] test_count;
    logic [9:0] min_time;
    logic [9:0] max_time;
    logic [9:0] avg_time;
    logic       avg_valid;
    logic       full;
    logic [5:0] foul_count;

    typedef struct {
        int avg;
        int cnt;
        int mn;
        int mx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_foul;

    reaction_stats dut (
        .clk_50M      (clk_50M),
        .clear        (clear),
        .result_valid (result_valid),
        .result_time  (result_time),
        .result_foul  (result_foul),
        .test_count   (test_count),
        .min_time     (min_time),
        .max_time     (max_time),
        .avg_time     (avg_time),
        .avg_valid    (avg_valid),
        .full         (full),
        .foul_count   (foul_count)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int avg, input int cnt, input int mn, input int mx);
        exp_t e;
        e.avg = avg; e.cnt = cnt; e.mn = mn; e.mx = mx;
        sb.push_back(e);
    endtask

    task automatic send(input int t, input bit foul);
        @(negedge clk_50M);
        result_valid = 1'b1;
        result_time  = 10'(t);
        result_foul  = foul;
        @(negedge clk_50M);
        result_valid = 1'b0;
        result_foul  = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk_50M);
        clear = 1'b1;
        @(negedge clk_50M);
        clear = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_count"}, int'(test_count), 0);
        chk({tag, "_min"}, int'(min_time), 1023);
        chk({tag, "_max"}, int'(max_time), 0);
        chk({tag, "_avg"}, int'(avg_time), 0);
        chk({tag, "_avg_valid"}, int'(avg_valid), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_foul"}, int'(foul_count), 0);
    endtask

    // Monitor: every rising avg_valid is a completed result, compared against the queue head.
    initial begin
        bit prev = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk_50M);
            if (clear) begin
                prev = 1'b1;
            end else begin
                if (avg_valid && !prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_avg", int'(avg_time), e.avg);
                        chk("sb_count", int'(test_count), e.cnt);
                        chk("sb_min", int'(min_time), e.mn);
                        chk("sb_max", int'(max_time), e.mx);
                    end
                end
                prev = avg_valid;
            end
        end
    end

    initial begin
`ifdef REACTION_STATS_FOUL_CNT_EN
        exp_foul = 1;
`else
        exp_foul = 0;
`endif
        clear = 1'b1;
        result_valid = 1'b0;
        result_time = '0;
        result_foul = 1'b0;
        #5;
        check_reset("rst");

        // First edge after release carries an accept; then 300 and 250.
        @(negedge clk_50M);
        clear = 1'b0;
        result_valid = 1'b1;
        result_time = 10'd200;
        @(negedge clk_50M);
        result_valid = 1'b0;
        push(200, 1, 200, 200);
        repeat (20) @(negedge clk_50M);
        send(300, 1'b0);
        push(250, 2, 200, 300);
        repeat (20) @(negedge clk_50M);
        send(250, 1'b0);
        push(250, 3, 200, 300);
        repeat (20) @(negedge clk_50M);

        // Foul leaves the statistics untouched.
        send(50, 1'b1);
        @(negedge clk_50M);
        chk("foul_avg_valid", int'(avg_valid), 1);
        chk("foul_count_stats", int'(test_count), 3);
        chk("foul_min", int'(min_time), 200);
        chk("foul_max", int'(max_time), 300);
        chk("foul_avg", int'(avg_time), 250);
        chk("foul_cnt", int'(foul_count), exp_foul);

        // Exact latency: 100 then 101 -> avg 100 on edge 15.
        do_clear();
        send(100, 1'b0);
        push(100, 1, 100, 100);
        repeat (15) @(negedge clk_50M);
        send(101, 1'b0);
        push(100, 2, 100, 101);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_50M);
            if (k < 15) begin
                chk($sformatf("lat_valid_e%0d", k), int'(avg_valid), 0);
                chk($sformatf("lat_hold_e%0d", k), int'(avg_time), 100);
            end else begin
                chk("lat_valid_e15", int'(avg_valid), 1);
                chk("lat_avg_e15", int'(avg_time), 100);
            end
        end
        repeat (5) @(negedge clk_50M);

        // Accept mid-division restarts it; avg holds 0 meanwhile.
        do_clear();
        send(500, 1'b0);
        repeat (3) @(negedge clk_50M);
        send(200, 1'b0);
        push(350, 2, 200, 500);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_50M);
            if (k < 15) begin
                chk($sformatf("abort_avg_e%0d", k), int'(avg_time), 0);
                chk($sformatf("abort_valid_e%0d", k), int'(avg_valid), 0);
            end else begin
                chk("abort_avg_e15", int'(avg_time), 350);
                chk("abort_valid_e15", int'(avg_valid), 1);
            end
        end
        repeat (5) @(negedge clk_50M);

        // Saturation: 16 x 999, the 16th is ignored.
        do_clear();
        for (int i = 0; i < 16; i++) send(999, 1'b0);
        push(999, 15, 999, 999);
        repeat (20) @(negedge clk_50M);
        chk("sat_full", int'(full), 1);
        chk("sat_count", int'(test_count), 15);
        chk("sat_max", int'(max_time), 999);

        // Clamp above 999.
        do_clear();
        send(1020, 1'b0);
        push(999, 1, 999, 999);
        repeat (20) @(negedge clk_50M);

        // Clear three cycles into a division.
        do_clear();
        send(400, 1'b0);
        repeat (3) @(negedge clk_50M);
        #2 clear = 1'b1;
        #1 check_reset("mid_div_clr");
        @(negedge clk_50M);
        clear = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_50M);
            chk($sformatf("post_clr_avg_%0d", k), int'(avg_time), 0);
            chk($sformatf("post_clr_valid_%0d", k), int'(avg_valid), 1);
        end

        repeat (5) @(negedge clk_50M);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
